lut_table_loader: RTL



---
 rtl/lut_table_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lut_table_loader.sv
// Key/data table loader: valid/ready writes fill slots contiguously (matching keys update in place), table exported as a flat lut bus.
// Query path: one registered stage, read-before-write; wr_ready drops while clr is high or when the table is full and the key is new.
module lut_table_loader #(
    parameter int  KEY_NUM  = 4,
    parameter int  KEY_LEN  = 2,
    parameter int  DATA_LEN = 4,
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN,
    localparam int CNT_W    = $clog2(KEY_NUM + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [KEY_LEN-1:0]           wr_key,
    input  logic [DATA_LEN-1:0]          wr_data,
    output logic [KEY_NUM*PAIR_LEN-1:0]  lut,
    output logic [KEY_NUM-1:0]           entry_valid,
    output logic [CNT_W-1:0]             count,
    output logic                         full,
    input  logic                         q_valid,
    input  logic [KEY_LEN-1:0]           q_key,
    output logic                         q_out_valid,
    output logic                         q_hit,
    output logic [DATA_LEN-1:0]          q_data
);

    logic [KEY_NUM-1:0][KEY_LEN-1:0]  key_q, key_d;
    logic [KEY_NUM-1:0][DATA_LEN-1:0] data_q, data_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic                             full_q, full_d;
    logic                             q_out_valid_q, q_out_valid_d;
    logic                             q_hit_q, q_hit_d;
    logic [DATA_LEN-1:0]              q_data_q, q_data_d;

    logic [KEY_NUM-1:0] occ;
    logic [KEY_NUM-1:0] wr_sel;
    logic               wr_match;
    logic               wr_fire;

    // Slots fill contiguously from 0, so occupancy is a thermometer of count.
    always_comb begin
        occ = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            occ[i] = (CNT_W'(i) < count_q);
        end
    end

    // Scan high to low so the lowest matching index wins.
    always_comb begin
        wr_match = 1'b0;
        wr_sel   = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (occ[i] && (key_q[i] == wr_key)) begin
                wr_match  = 1'b1;
                wr_sel    = '0;
                wr_sel[i] = 1'b1;
            end
        end
    end

    assign wr_ready = !clr && (wr_match || !full_q);
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        key_d   = key_q;
        data_d  = data_q;
        count_d = count_q;
        if (clr) begin
            key_d   = '0;
            data_d  = '0;
            count_d = '0;
        end else if (wr_fire) begin
            if (wr_match) begin
                for (int i = 0; i < KEY_NUM; i++) begin
                    if (wr_sel[i]) data_d[i] = wr_data;
                end
            end else begin
                for (int i = 0; i < KEY_NUM; i++) begin
                    if (CNT_W'(i) == count_q) begin
                        key_d[i]  = wr_key;
                        data_d[i] = wr_data;
                    end
                end
                count_d = count_q + CNT_W'(1);
            end
        end
        full_d = (count_d == CNT_W'(KEY_NUM));
    end

    // Query reads the pre-edge table; results hold while no query is issued.
    always_comb begin
        q_out_valid_d = q_valid;
        q_hit_d       = q_hit_q;
        q_data_d      = q_data_q;
        if (q_valid) begin
            q_hit_d  = 1'b0;
            q_data_d = '0;
            for (int i = KEY_NUM - 1; i >= 0; i--) begin
                if (occ[i] && (key_q[i] == q_key)) begin
                    q_hit_d  = 1'b1;
                    q_data_d = data_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q         <= '0;
            data_q        <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            q_out_valid_q <= 1'b0;
            q_hit_q       <= 1'b0;
            q_data_q      <= '0;
        end else begin
            key_q         <= key_d;
            data_q        <= data_d;
            count_q       <= count_d;
            full_q        <= full_d;
            q_out_valid_q <= q_out_valid_d;
            q_hit_q       <= q_hit_d;
            q_data_q      <= q_data_d;
        end
    end

    always_comb begin
        lut = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (occ[i]) lut[PAIR_LEN*i +: PAIR_LEN] = {key_q[i], data_q[i]};
        end
    end

    assign entry_valid = occ;
    assign count       = count_q;
    assign full        = full_q;
    assign q_out_valid = q_out_valid_q;
    assign q_hit       = q_hit_q;
    assign q_data      = q_data_q;

endmodule
